// File: rtl/uart_mem_bridge.sv
// Executes decoded UART packets against instruction/data memory; read data
// is returned to the byte transmitter MSB-first, writes optionally acknowledged.
module uart_mem_bridge #(
  parameter int         ADDR_BITS      = 9,
  parameter int         MEM_RD_LATENCY = 1,
  parameter bit         WRITE_ACK      = 1'b1,
  parameter logic [7:0] ACK_BYTE       = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_done,
  input  logic [31:0]          rx_data,
  input  logic [ADDR_BITS-1:0] rx_addr,
  input  logic                 rx_mem_type,
  input  logic                 rx_rw_flag,
  output logic                 mem_sel,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [31:0]          mem_rdata,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 busy,
  output logic                 cmd_drop
);

  // state     | meaning
  // IDLE      | waiting for a packet
  // WRITE     | mem_we strobe cycle
  // READ_REQ  | mem_re strobe cycle, arm latency counter
  // READ_WAIT | count down read latency, capture mem_rdata at terminal count
  // SEND      | wait for transmitter idle, issue tx_start
  // TX_GAP    | let the transmitter raise tx_busy
  // TX_WAIT   | wait for byte done, shift to next byte or finish
  typedef enum logic [2:0] {
    IDLE, WRITE, READ_REQ, READ_WAIT, SEND, TX_GAP, TX_WAIT
  } state_t;

  localparam logic [2:0] RD_LAT = 3'(MEM_RD_LATENCY);

  state_t      state;
  logic [31:0] shift_q;
  logic [2:0]  byte_cnt;
  logic [2:0]  byte_tgt;
  logic [2:0]  wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_q   <= '0;
      byte_cnt  <= '0;
      byte_tgt  <= '0;
      wait_cnt  <= '0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      cmd_drop  <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      tx_start <= 1'b0;
      // Packets arriving mid-operation (including the exit cycle) are discarded
      cmd_drop <= rx_done && (state != IDLE);
      case (state)
        IDLE: begin
          if (rx_done) begin
            mem_sel   <= rx_mem_type;
            mem_addr  <= rx_addr;
            mem_wdata <= rx_data;
            byte_cnt  <= '0;
            busy      <= 1'b1;
            if (rx_rw_flag) begin
              mem_we <= 1'b1;
              state  <= WRITE;
            end else begin
              mem_re <= 1'b1;
              state  <= READ_REQ;
            end
          end
        end
        WRITE: begin
          if (WRITE_ACK) begin
            shift_q  <= {ACK_BYTE, 24'h000000};
            byte_tgt <= 3'd1;
            state    <= SEND;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        READ_REQ: begin
          wait_cnt <= RD_LAT;
          state    <= READ_WAIT;
        end
        READ_WAIT: begin
          if (wait_cnt == 3'd1) begin
            wait_cnt <= '0;
            shift_q  <= mem_rdata;
            byte_tgt <= 3'd4;
            state    <= SEND;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_data  <= shift_q[31:24];
            tx_start <= 1'b1;
            state    <= TX_GAP;
          end
        end
        TX_GAP: state <= TX_WAIT;
        TX_WAIT: begin
          if (!tx_busy) begin
            shift_q  <= {shift_q[23:0], 8'h00};
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt + 3'd1 == byte_tgt) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= SEND;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
